// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the multi-cycle CPU control sequencer: state encoding and
// the decoded instruction class latched at the end of DECODE.
package cpu_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_FAULT     = 3'd7
    } state_e;

    typedef struct packed {
        logic load;
        logic store;
        logic branch;
        logic halt;
    } instr_class_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts request cycles that pass without an acknowledge; flags a timeout in
// the last allowed request cycle when no ack arrives in it.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic ack,
    output logic timeout
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !ack) begin
            cnt <= cnt + W'(1);
        end
    end

    // cnt holds the number of earlier unacknowledged cycles, so cycle k sees k-1;
    // an ack in the final cycle still wins.
    assign timeout = count_en && !ack && (cnt == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control FSM with memory
// handshakes, timeout fault, sticky halt/fault and a saturating retire counter.
module cpu_stage_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    input  logic               imem_ack,
    output logic               en_ir,
    output logic               en_decode,
    input  logic               dec_is_load,
    input  logic               dec_is_store,
    input  logic               dec_is_branch,
    input  logic               dec_is_halt,
    output logic               en_exec,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               en_wb,
    output logic               en_pc,
    output logic               pc_sel_branch,
    output logic               halted,
    output logic               fault,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   instr_count
);

    state_e       state;
    state_e       state_nxt;
    instr_class_t flags;
    logic         waiting;
    logic         wait_ack;
    logic         wait_clear;
    logic         timeout;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            flags <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_DECODE) begin
                flags <= {dec_is_load, dec_is_store, dec_is_branch, dec_is_halt};
            end
        end
    end

    // Only the ack belonging to the current request state reaches the timer.
    assign waiting    = (state == ST_FETCH) || (state == ST_MEMORY);
    assign wait_ack   = (state == ST_FETCH) ? imem_ack : dmem_ack;
    assign wait_clear = (state_nxt != state);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .count_en(waiting),
        .ack     (wait_ack),
        .timeout (timeout)
    );

    always_comb begin
        state_nxt     = state;
        imem_req      = 1'b0;
        en_ir         = 1'b0;
        en_decode     = 1'b0;
        en_exec       = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        en_wb         = 1'b0;
        en_pc         = 1'b0;
        pc_sel_branch = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                en_ir    = imem_ack;
                if (imem_ack)     state_nxt = ST_DECODE;
                else if (timeout) state_nxt = ST_FAULT;
            end
            ST_DECODE: begin
                en_decode = 1'b1;
                if (dec_is_halt)                      state_nxt = ST_HALT;
                else if (dec_is_load && dec_is_store) state_nxt = ST_FAULT;
                else                                  state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                en_exec = 1'b1;
                if (flags.branch) begin
                    en_pc         = 1'b1;
                    pc_sel_branch = 1'b1;
                    state_nxt     = ST_FETCH;
                end else if (flags.load || flags.store) begin
                    state_nxt = ST_MEMORY;
                end else begin
                    state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = flags.store;
                if (dmem_ack) begin
                    if (flags.store) begin
                        en_pc     = 1'b1;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WRITEBACK;
                    end
                end else if (timeout) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_WRITEBACK: begin
                en_wb     = 1'b1;
                en_pc     = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default:  state_nxt = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (en_pc && (instr_count != '1)) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Bench for cpu_stage_sequencer: per-instruction cycle traces are built from
// the stage rules, then replayed against the DUT with random ignored inputs.
module tb_cpu_stage_sequencer;

    localparam int T     = 4;
    localparam int CNT_W = 3;
    localparam int W     = 14;

    localparam logic [10:0] IREQ = 11'h400;
    localparam logic [10:0] IR   = 11'h200;
    localparam logic [10:0] DEC  = 11'h100;
    localparam logic [10:0] EXE  = 11'h080;
    localparam logic [10:0] DREQ = 11'h040;
    localparam logic [10:0] DWE  = 11'h020;
    localparam logic [10:0] WB   = 11'h010;
    localparam logic [10:0] PC   = 11'h008;
    localparam logic [10:0] PCB  = 11'h004;
    localparam logic [10:0] HLT  = 11'h002;
    localparam logic [10:0] FLT  = 11'h001;

    logic clk, reset, start, imem_ack, dmem_ack;
    logic dec_is_load, dec_is_store, dec_is_branch, dec_is_halt;
    logic imem_req, en_ir, en_decode, en_exec, dmem_req, dmem_we;
    logic en_wb, en_pc, pc_sel_branch, halted, fault;
    logic [2:0] state_o;
    logic [CNT_W-1:0] instr_count;
    logic [W-1:0] obs;

    logic [W-1:0]     exp_q[$];
    logic [6:0]       stim_q[$];
    logic [CNT_W-1:0] cnt_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mcnt = 0;
    bit dead;

    cpu_stage_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .en_ir(en_ir),
        .en_decode(en_decode), .dec_is_load(dec_is_load),
        .dec_is_store(dec_is_store), .dec_is_branch(dec_is_branch),
        .dec_is_halt(dec_is_halt), .en_exec(en_exec), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_ack(dmem_ack), .en_wb(en_wb), .en_pc(en_pc),
        .pc_sel_branch(pc_sel_branch), .halted(halted), .fault(fault),
        .state_o(state_o), .instr_count(instr_count)
    );

    assign obs = {imem_req, en_ir, en_decode, en_exec, dmem_req, dmem_we,
                  en_wb, en_pc, pc_sel_branch, halted, fault, state_o};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [W-1:0] ev(input logic [10:0] f, input int st);
        return {f, 3'(st)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] o, input logic [CNT_W-1:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, o, e);
        end
    endtask

    // driver: one queued cycle = inputs, expected outputs, expected count
    task automatic push(input logic st, input logic ia, input logic da,
                        input logic [3:0] dec, input logic [W-1:0] e);
        stim_q.push_back({st, ia, da, dec});
        exp_q.push_back(e);
        cnt_q.push_back(CNT_W'(mcnt));
    endtask

    task automatic retire();
        if (mcnt < (1 << CNT_W) - 1) mcnt++;
    endtask

    task automatic push_fault();
        for (int i = 0; i < 2; i++) push(rb(), rb(), rb(), r4(), ev(FLT, 7));
        dead = 1;
    endtask

    task automatic gen_fetch(input int fd, output bit ok);
        ok = 0;
        for (int k = 1; k <= T; k++) begin
            logic ia;
            ia = (k == fd);
            push(rb(), ia, rb(), r4(), ev(IREQ | (ia ? IR : 11'h0), 1));
            if (ia) begin
                ok = 1;
                break;
            end
        end
        if (!ok) push_fault();
    endtask

    task automatic gen_mem(input int md, input logic store, output bit ok);
        ok = 0;
        for (int k = 1; k <= T; k++) begin
            logic da;
            da = (k == md);
            push(rb(), rb(), da, r4(),
                 ev(DREQ | (store ? DWE : 11'h0) | ((da && store) ? PC : 11'h0), 4));
            if (da) begin
                if (store) retire();
                ok = 1;
                break;
            end
        end
        if (!ok) push_fault();
    endtask

    // cls: 0 alu, 1 load, 2 store, 3 branch, 4 halt, 5 load+store (illegal)
    task automatic gen_instr(input int cls, input int fd, input int md);
        bit ok;
        logic [3:0] dec;
        gen_fetch(fd, ok);
        if (!ok) return;
        case (cls)
            1:       dec = 4'b1000;
            2:       dec = 4'b0100;
            3:       dec = 4'b0010;
            4:       dec = {rb(), rb(), rb(), 1'b1};
            5:       dec = {2'b11, rb(), 1'b0};
            default: dec = 4'b0000;
        endcase
        push(rb(), rb(), rb(), dec, ev(DEC, 2));
        if (cls == 4) begin
            push(1'b1, rb(), rb(), r4(), ev(HLT, 6));
            for (int i = 0; i < 2; i++) push(rb(), rb(), rb(), r4(), ev(HLT, 6));
            dead = 1;
            return;
        end
        if (cls == 5) begin
            push_fault();
            return;
        end
        if (cls == 3) begin
            push(rb(), rb(), rb(), r4(), ev(EXE | PC | PCB, 3));
            retire();
            return;
        end
        push(rb(), rb(), rb(), r4(), ev(EXE, 3));
        if (cls == 1 || cls == 2) begin
            gen_mem(md, cls == 2, ok);
            if (!ok || cls == 2) return;
        end
        push(rb(), rb(), rb(), r4(), ev(WB | PC, 5));
        retire();
    endtask

    task automatic play();
        logic [6:0] s;
        logic [W-1:0] e;
        logic [CNT_W-1:0] c;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            @(negedge clk);
            {start, imem_ack, dmem_ack, dec_is_load, dec_is_store,
             dec_is_branch, dec_is_halt} = s;
            #1;
            cyc++;
            chk("cycle_outputs", obs, e);
            chk_cnt("instr_count", instr_count, c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        {start, imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_is_branch, dec_is_halt} = 7'h7f;
        #1;
        chk("reset_outputs", obs, '0);
        chk_cnt("reset_count", instr_count, '0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        mcnt = 0;
        dead = 0;
        push(1'b0, rb(), rb(), r4(), ev(11'h0, 0));
        push(1'b1, rb(), rb(), r4(), ev(11'h0, 0));
    endtask

    task automatic gen_random_prog(input int n);
        for (int i = 0; i < n && !dead; i++) begin
            int fd, md;
            fd = $urandom_range(1, T);
            md = $urandom_range(1, T);
            if ($urandom_range(0, 15) == 0) fd = T + 1;
            if ($urandom_range(0, 15) == 0) md = T + 1;
            gen_instr($urandom_range(0, 3), fd, md);
        end
        if (!dead) gen_instr(4, 1, 1);
    endtask

    initial begin
        bit ok;
        reset = 1'b0;
        {start, imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_is_branch, dec_is_halt} = '0;
        repeat (2) @(posedge clk);

        // directed: alu, slow load, store, branch, then random mix up to saturation
        do_reset();
        gen_instr(0, 2, 1);
        gen_instr(1, 1, 3);
        gen_instr(2, 1, 1);
        gen_instr(3, 1, 1);
        for (int i = 0; i < 6; i++) gen_instr($urandom_range(0, 3), $urandom_range(1, T), $urandom_range(1, T));
        gen_instr(4, 1, 1);
        play();

        // fetch timeout, then ack in the final fetch cycle and a data timeout
        do_reset();
        gen_instr(0, T + 1, 1);
        play();
        do_reset();
        gen_instr(0, T, 1);
        gen_instr(1, 1, T + 1);
        play();
        do_reset();
        gen_instr(2, 1, T);
        gen_instr(5, 1, 1);
        play();

        for (int p = 0; p < 6; p++) begin
            do_reset();
            gen_random_prog(10);
            play();
        end

        // asynchronous reset in the middle of a data request
        do_reset();
        gen_instr(0, 1, 1);
        gen_fetch(1, ok);
        push(1'b0, 1'b0, 1'b0, 4'b1000, ev(DEC, 2));
        push(1'b0, 1'b0, 1'b0, 4'b0000, ev(EXE, 3));
        push(1'b0, 1'b0, 1'b0, 4'b0000, ev(DREQ, 4));
        play();
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        chk("mid_mem_req_before", {13'h0, dmem_req}, 14'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_mem_outputs", obs, '0);
        chk_cnt("mid_mem_count", instr_count, '0);
        @(negedge clk);
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
